// File: rtl/operand_capture.sv
// Operand entry front-end: synchronises switches and buttons, debounces the
// buttons, and latches switch values into operands A/B on debounced presses.

module oc_debounce #(
  parameter int DB_BITS  = 20,
  parameter int DB_COUNT = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_i,
  output logic pulse_o
);
  localparam logic [DB_BITS-1:0] LAST = DB_BITS'(DB_COUNT - 1);

  logic               sync1_q, sync2_q;
  logic               deb_q, deb_d, deb_prev_q, pulse_q;
  logic [DB_BITS-1:0] cnt_q, cnt_d;

  // Any sample agreeing with the debounced state restarts the full window.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (cnt_q == LAST) deb_d = sync2_q;
      else               cnt_d = cnt_q + DB_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      deb_q      <= 1'b0;
      deb_prev_q <= 1'b0;
      cnt_q      <= '0;
      pulse_q    <= 1'b0;
    end else begin
      sync1_q    <= raw_i;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      cnt_q      <= cnt_d;
      deb_prev_q <= deb_q;
      pulse_q    <= deb_q & ~deb_prev_q;
    end
  end

  assign pulse_o = pulse_q;
endmodule

module operand_capture #(
  parameter int WIDTH    = 4,
  parameter int DB_BITS  = 20,
  parameter int DB_COUNT = 500000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load_a,
  input  logic             btn_load_b,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             a_loaded,
  output logic             b_loaded,
  output logic             valid
);
  localparam int NUM_BTN = 3;

  // State bit 0 = A loaded, bit 1 = B loaded.
  typedef enum logic [1:0] {
    EMPTY  = 2'b00,
    HAVE_A = 2'b01,
    HAVE_B = 2'b10,
    READY  = 2'b11
  } state_t;

  logic [NUM_BTN-1:0] btn_raw, btn_pulse;
  logic               ld_a, ld_b, clr;
  logic [WIDTH-1:0]   sw_s1_q, sw_s2_q, a_q, b_q;
  logic               valid_q;
  state_t             state_q, state_d;

  assign btn_raw = {btn_clear, btn_load_b, btn_load_a};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    oc_debounce #(.DB_BITS(DB_BITS), .DB_COUNT(DB_COUNT)) u_db (
      .clk     (clk),
      .rst     (rst),
      .raw_i   (btn_raw[g]),
      .pulse_o (btn_pulse[g])
    );
  end

  assign ld_a = btn_pulse[0];
  assign ld_b = btn_pulse[1];
  assign clr  = btn_pulse[2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= EMPTY;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (ld_a && ld_b) state_d = READY;
          else if (ld_a)    state_d = HAVE_A;
          else if (ld_b)    state_d = HAVE_B;
        end
        HAVE_A:  if (ld_b) state_d = READY;
        HAVE_B:  if (ld_a) state_d = READY;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    a_loaded = (state_q == HAVE_A) || (state_q == READY);
    b_loaded = (state_q == HAVE_B) || (state_q == READY);
  end

  // Operands take the synchronised switch value; clear wins over loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      sw_s1_q <= sw;
      sw_s2_q <= sw_s1_q;
      valid_q <= a_loaded & b_loaded;
      if (clr) begin
        a_q <= '0;
        b_q <= '0;
      end else begin
        if (ld_a) a_q <= sw_s2_q;
        if (ld_b) b_q <= sw_s2_q;
      end
    end
  end

  assign a     = a_q;
  assign b     = b_q;
  assign valid = valid_q;
endmodule

// File: tb/tb_operand_capture.sv
// Randomised bench for operand_capture: a sliding-window reference model
// predicts every output change and its cycle; a monitor checks each change.

module tb_operand_capture;
  localparam int WIDTH    = 4;
  localparam int DB_BITS  = 3;
  localparam int DB_COUNT = 4;
  localparam int TW       = 2*WIDTH + 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [WIDTH-1:0] sw = '0;
  logic             btn_load_a = 1'b0, btn_load_b = 1'b0, btn_clear = 1'b0;
  logic [WIDTH-1:0] a, b;
  logic             a_loaded, b_loaded, valid;

  operand_capture #(.WIDTH(WIDTH), .DB_BITS(DB_BITS), .DB_COUNT(DB_COUNT)) dut (
    .clk(clk), .rst(rst), .sw(sw),
    .btn_load_a(btn_load_a), .btn_load_b(btn_load_b), .btn_clear(btn_clear),
    .a(a), .b(b), .a_loaded(a_loaded), .b_loaded(b_loaded), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct { int stamp; logic [TW-1:0] tup; } exp_t;
  exp_t expq[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0, miscompares = 0;
  bit done = 1'b0;

  // Reference model: a button's debounced level flips once the last DB_COUNT
  // synchronised samples all disagree with it; a rise yields a press one edge later.
  bit [2:0]         m_s1 = '0, m_s2 = '0, m_deb = '0, m_rose = '0, m_pulse = '0;
  logic [WIDTH-1:0] m_sw1 = '0, m_sw2 = '0, m_a = '0, m_b = '0;
  bit               m_al = 0, m_bl = 0, m_valid = 0;
  bit               win[3][$];
  logic [TW-1:0]    m_last = '0;

  always @(posedge clk or posedge rst) begin
    logic [TW-1:0] t;
    int  stamp;
    bit  nv, all_diff;
    if (rst) begin
      stamp = cyc;
      m_s1 = '0; m_s2 = '0; m_deb = '0; m_rose = '0; m_pulse = '0;
      m_sw1 = '0; m_sw2 = '0; m_a = '0; m_b = '0;
      m_al = 0; m_bl = 0; m_valid = 0;
      for (int k = 0; k < 3; k++) win[k].delete();
    end else begin
      stamp = cyc + 1;
      nv = m_al & m_bl;
      if (m_pulse[2]) begin
        m_a = '0; m_b = '0; m_al = 0; m_bl = 0;
      end else begin
        if (m_pulse[0]) begin m_a = m_sw2; m_al = 1; end
        if (m_pulse[1]) begin m_b = m_sw2; m_bl = 1; end
      end
      m_valid = nv;
      for (int k = 0; k < 3; k++) begin
        m_pulse[k] = m_rose[k];
        m_rose[k]  = 0;
        win[k].push_back(m_s2[k]);
        if (win[k].size() > DB_COUNT) void'(win[k].pop_front());
        if (win[k].size() == DB_COUNT) begin
          all_diff = 1;
          for (int j = 0; j < win[k].size(); j++)
            if (win[k][j] == m_deb[k]) all_diff = 0;
          if (all_diff) begin
            m_deb[k]  = ~m_deb[k];
            m_rose[k] = m_deb[k];
          end
        end
      end
      m_s2 = m_s1; m_s1 = {btn_clear, btn_load_b, btn_load_a};
      m_sw2 = m_sw1; m_sw1 = sw;
    end
    t = {m_a, m_b, m_al, m_bl, m_valid};
    if (t != m_last) begin
      expq.push_back('{stamp, t});
      m_last = t;
    end
  end

  // Monitor
  logic [TW-1:0] last_obs = '0;

  task automatic observe();
    logic [TW-1:0] cur;
    exp_t e;
    cur = {a, b, a_loaded, b_loaded, valid};
    if (cur !== last_obs) begin
      vectors++;
      if (expq.size() == 0) begin
        miscompares++;
        $display("FAIL out_change cyc=%0d got=%h required=no change", cyc, cur);
      end else begin
        e = expq.pop_front();
        if (e.tup !== cur || e.stamp != cyc) begin
          miscompares++;
          $display("FAIL out_change got=%h@cyc%0d required=%h@cyc%0d", cur, cyc, e.tup, e.stamp);
        end
      end
      last_obs = cur;
    end
  endtask

  always @(negedge clk or posedge rst) begin
    if (done) begin
      vectors++;
      if (expq.size() != 0) begin
        miscompares++;
        $display("FAIL pending_changes got=%0d outstanding required=0", expq.size());
      end
      vectors++;
      if ({a, b, a_loaded, b_loaded, valid} !== m_last) begin
        miscompares++;
        $display("FAIL final_state got=%h required=%h", {a, b, a_loaded, b_loaded, valid}, m_last);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
    end else if (rst) begin
      #1;
      vectors++;
      if ({a, b, a_loaded, b_loaded, valid} !== '0) begin
        miscompares++;
        $display("FAIL reset_zero got=%h required=0", {a, b, a_loaded, b_loaded, valid});
      end
      observe();
    end else begin
      observe();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise rst just after the given number of rising edges, hold, release on a falling edge.
  task automatic async_rst(input int edges, input int hold);
    repeat (edges) @(posedge clk);
    #2 rst = 1'b1;
    tick(hold);
    rst = 1'b0;
  endtask

  initial begin
    int rem[3];
    bit [2:0] bv;
    tick(3);
    rst = 1'b0;
    tick(2);

    sw = 4'h5; btn_load_a = 1'b1; tick(20); btn_load_a = 1'b0; tick(10);
    sw = 4'hA; btn_load_b = 1'b1; tick(20); btn_load_b = 1'b0; tick(10);

    sw = 4'h3;
    for (int i = 0; i < 15; i++) begin btn_load_a = ~btn_load_a; tick(2); end
    btn_load_a = 1'b0; tick(12);

    btn_clear = 1'b1; btn_load_a = 1'b1; tick(20);
    btn_clear = 1'b0; btn_load_a = 1'b0; tick(10);

    sw = 4'h9; btn_load_a = 1'b1; btn_load_b = 1'b1; tick(20);
    btn_load_a = 1'b0; btn_load_b = 1'b0; tick(6);
    async_rst(1, 3); tick(4);

    sw = 4'h6; btn_load_b = 1'b1;
    async_rst(2, 3);
    tick(20); btn_load_b = 1'b0; tick(10);

    for (int k = 0; k < 3; k++) rem[k] = $urandom_range(1, 10);
    bv = '0;
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (rem[k] == 0) begin
          bv[k] = ~bv[k];
          rem[k] = (k == 2 && !bv[k]) ? $urandom_range(10, 60) : $urandom_range(1, 10);
        end else begin
          rem[k]--;
        end
      end
      {btn_clear, btn_load_b, btn_load_a} = bv;
      if ($urandom_range(0, 3) == 0) sw = WIDTH'($urandom);
      tick(1);
    end
    {btn_clear, btn_load_b, btn_load_a} = 3'b000;
    tick(20);
    done = 1'b1;
  end
endmodule
